tiger_dshift_ctrl: RTL

Multi-cycle 64-bit shift sequencer for the Tiger datapath. It performs SLL, SRL or SRA on a {hi,lo} register pair by amounts 0-63. All shift work goes through a single instance of the existing 32-bit combinational barrel shifter (tiger_shifter), time-multiplexed over up to 3 cycles. A start/busy/done handshake lets the pipeline stall while a long shift runs.

---
 rtl/tiger_dshift_pkg.sv | 16 +
 rtl/tiger_dshift_if.sv | 26 ++
 rtl/tiger_shifter.sv | 22 ++
 rtl/tiger_dshift_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/tiger_dshift_pkg.sv
// Shared constants for the Tiger 64-bit shift sequencer and its 32-bit barrel shifter.
package tiger_dshift_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned AMT_W  = 6;
  localparam int unsigned SH_W   = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OP_A = 2'd1;
  localparam logic [1:0] S_OP_B = 2'd2;
  localparam logic [1:0] S_OP_C = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/tiger_dshift_if.sv
// Request/result bundle between the pipeline (master) and the shift sequencer (slave).
interface tiger_dshift_if;
  import tiger_dshift_pkg::*;

  logic              start;
  logic              dir;
  logic              alusigned;
  logic [AMT_W-1:0]  amt;
  logic [WORD_W-1:0] src_hi;
  logic [WORD_W-1:0] src_lo;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] res_hi;
  logic [WORD_W-1:0] res_lo;

  modport master (
    output start, dir, alusigned, amt, src_hi, src_lo,
    input  busy, done, res_hi, res_lo
  );

  modport slave (
    input  start, dir, alusigned, amt, src_hi, src_lo,
    output busy, done, res_hi, res_lo
  );

endinterface

// File: rtl/tiger_shifter.sv
// 32-bit combinational barrel shifter: logical left, logical or arithmetic right.
module tiger_shifter
  import tiger_dshift_pkg::*;
(
  input  logic [WORD_W-1:0] src,
  input  logic [SH_W-1:0]   amt,
  input  logic              dir,
  input  logic              alusigned,
  output logic [WORD_W-1:0] res_c
);

  always_comb begin
    if (dir == DIR_LEFT) begin
      res_c = src << amt;
    end else if (alusigned) begin
      res_c = WORD_W'($signed(src) >>> amt);
    end else begin
      res_c = src >> amt;
    end
  end

endmodule

// File: rtl/tiger_dshift_ctrl.sv
// 64-bit shift sequencer: time-multiplexes one 32-bit shifter over up to three op cycles.
module tiger_dshift_ctrl
  import tiger_dshift_pkg::*;
#(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  tiger_dshift_if.slave bus
);

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] res_hi_q, res_hi_d;
  logic [WORD_W-1:0] res_lo_q, res_lo_d;

  logic              dir_q, sgn_q, bypass_q;
  logic [AMT_W-1:0]  amt_q;
  logic [WORD_W-1:0] hi_q, lo_q;

  logic              accept_c;
  logic              single_c;
  logic              fill_c;
  logic [SH_W-1:0]   k_c;
  logic [WORD_W-1:0] sh_src_c;
  logic [SH_W-1:0]   sh_amt_c;
  logic              sh_dir_c;
  logic              sh_sgn_c;
  logic [WORD_W-1:0] sh_res_c;
  logic [WORD_W-1:0] or_term_c;

  assign accept_c = (state_q == S_IDLE) && bus.start;
  assign single_c = amt_q[AMT_W-1] || bypass_q;
  assign fill_c   = sgn_q && hi_q[WORD_W-1];
  assign k_c      = SH_W'(AMT_W'(32) - amt_q);

  // Operand latches, captured only on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q    <= 1'b0;
      sgn_q    <= 1'b0;
      bypass_q <= 1'b0;
      amt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (accept_c) begin
      dir_q    <= bus.dir;
      sgn_q    <= bus.alusigned && (bus.dir == DIR_RIGHT);
      bypass_q <= ZERO_BYPASS && (bus.amt == '0);
      amt_q    <= bus.amt;
      hi_q     <= bus.src_hi;
      lo_q     <= bus.src_lo;
    end
  end

  // Shifter operand steering; amt[4:0] equals both n (n<32) and m (n>=32)
  always_comb begin
    sh_src_c = hi_q;
    sh_amt_c = amt_q[SH_W-1:0];
    sh_dir_c = dir_q;
    sh_sgn_c = 1'b0;
    case (state_q)
      S_OP_A: begin
        sh_src_c = (dir_q == DIR_LEFT) ? lo_q : hi_q;
        sh_sgn_c = sgn_q;
      end
      S_OP_B: begin
        sh_src_c = (dir_q == DIR_LEFT) ? hi_q : lo_q;
      end
      S_OP_C: begin
        sh_src_c = (dir_q == DIR_LEFT) ? lo_q : hi_q;
        sh_amt_c = k_c;
        sh_dir_c = ~dir_q;
      end
      default: ;
    endcase
  end

  tiger_shifter u_shifter (
    .src       (sh_src_c),
    .amt       (sh_amt_c),
    .dir       (sh_dir_c),
    .alusigned (sh_sgn_c),
    .res_c     (sh_res_c)
  );

  // k wraps to 0 when n=0, so the cross-word term must vanish
  assign or_term_c = (amt_q == '0) ? '0 : sh_res_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_OP_A;
          busy_d  = 1'b1;
        end
      end
      S_OP_A: begin
        if (bypass_q) begin
          res_hi_d = hi_q;
          res_lo_d = lo_q;
        end else if (amt_q[AMT_W-1]) begin
          if (dir_q == DIR_LEFT) begin
            res_hi_d = sh_res_c;
            res_lo_d = '0;
          end else begin
            res_hi_d = {WORD_W{fill_c}};
            res_lo_d = sh_res_c;
          end
        end else if (dir_q == DIR_LEFT) begin
          res_lo_d = sh_res_c;
        end else begin
          res_hi_d = sh_res_c;
        end
        if (single_c) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_OP_B;
        end
      end
      S_OP_B: begin
        if (dir_q == DIR_LEFT) res_hi_d = sh_res_c;
        else                   res_lo_d = sh_res_c;
        state_d = S_OP_C;
      end
      S_OP_C: begin
        if (dir_q == DIR_LEFT) res_hi_d = res_hi_q | or_term_c;
        else                   res_lo_d = res_lo_q | or_term_c;
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.res_hi = res_hi_q;
  assign bus.res_lo = res_lo_q;

endmodule
